serial_burst_router: RTL and testbench
======================================

SERIAL_BURST_ROUTER -- requirements
Module: serial_burst_router

Interface
REQ-001 SHALL have parameter CNT_W, default 8: burst-length counter width; legal lengths 1..2^CNT_W-1.
REQ-002 SHALL have parameter CHANNELS, default 4: number of serial output channels, minimum 2.
REQ-003 SHALL have parameter SEL_W, default 2: channel-select width, equal to clog2(CHANNELS).
REQ-004 SHALL have port clk  in  1  clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  in  1  burst request, sampled each rising edge.
REQ-007 SHALL have port len  in  CNT_W  burst length in bits, sampled with start.
REQ-008 SHALL have port ch_sel  in  SEL_W  destination channel, sampled with start.
REQ-009 SHALL have port abort  in  1  terminate the active burst.
REQ-010 SHALL have port serial_in  in  1  incoming serial bit.
REQ-011 SHALL have port serial_out  out  CHANNELS  per-channel serial data.
REQ-012 SHALL have port valid  out  CHANNELS  per-channel bit-valid strobe.
REQ-013 SHALL have port busy  out  1  burst in progress.
REQ-014 SHALL have port last  out  1  current bit is the final bit of the burst.
REQ-015 SHALL have port done  out  1  one-cycle completion pulse.
REQ-016 SHALL have port remaining  out  CNT_W  bits left, including the current bit.
REQ-017 SHALL have port err  out  2  one-cycle error pulse; bit0 = zero length, bit1 = start while not IDLE.

Function
REQ-018 SHALL implement the FSM states IDLE, SEND and DONE, all registered.
REQ-019 In IDLE, start=1 with len!=0 and abort=0 SHALL transition to SEND, load remaining=len and latch ch_sel into an internal active-channel register.
REQ-020 In IDLE, start=1 with len==0 SHALL remain in IDLE, pulse err[0] for one cycle and leave all other outputs unchanged.
REQ-021 In SEND, valid[active]=1 and all other valid bits SHALL be 0.
REQ-022 serial_out[active] SHALL equal serial_in combinationally while in SEND, and every other serial_out bit SHALL be 0.
REQ-023 In SEND, each rising edge SHALL decrement remaining by 1, so valid stays high for exactly len cycles.
REQ-024 last SHALL equal 1 when state is SEND and remaining==1, and 0 otherwise.
REQ-025 In SEND with remaining==1 and abort=0, the next edge SHALL transition to DONE with remaining set to 0.
REQ-026 DONE SHALL last exactly one cycle with done=1 and all valid bits 0, then transition to IDLE.
REQ-027 busy SHALL equal 1 in SEND and DONE, and 0 in IDLE.
REQ-028 In SEND, abort=1 SHALL cause the next edge to go to IDLE with remaining set to 0 and no done pulse; abort takes priority over the final-bit completion.
REQ-029 abort in IDLE or DONE SHALL have no effect; simultaneous start=1 and abort=1 in IDLE SHALL ignore start.
REQ-030 start=1 in SEND or DONE SHALL be ignored and SHALL pulse err[1] for one cycle without disturbing the burst.
REQ-031 A new start SHALL be accepted only in IDLE, giving a minimum of one IDLE cycle between bursts.
REQ-032 The counter SHALL never wrap; remaining SHALL stay at 0 outside SEND.
REQ-033 An out-of-range latched ch_sel (≥CHANNELS) SHALL still run the burst timing (busy, last, remaining, done) with no valid or serial_out bit asserted.

Reset
REQ-034 rst=1 SHALL immediately force state IDLE, remaining=0, active channel 0, and busy, last, done, err, valid and serial_out all to 0, regardless of clk.
REQ-035 rst asserted mid-burst SHALL abandon the burst with no done pulse, and the first edge after release SHALL behave as IDLE.

Verification
REQ-036 Bench SHALL cover: start, len=3, ch_sel=2 -> valid[2] high for 3 cycles; remaining 3,2,1; last on the 3rd cycle; done on the 4th; busy for 4 cycles.
REQ-037 Bench SHALL cover: start, len=0 -> err[0] pulses for 1 cycle; busy, valid and done stay 0.
REQ-038 Bench SHALL cover: len=5, abort asserted on the 2nd SEND cycle -> exactly 2 valid cycles; IDLE next; done never asserted.
REQ-039 Bench SHALL cover: start pulsed during SEND of a len=4 burst -> err[1] pulses once; burst still delivers 4 bits and then done.
REQ-040 Bench SHALL cover: len=255 with CNT_W=8 -> exactly 255 valid cycles and no counter wrap.
REQ-041 Bench SHALL cover: rst asserted on the 2nd cycle of a len=6 burst -> all outputs 0 asynchronously; a new start, len=1 after release -> 1 valid cycle, then done.

Source files
------------

// File: rtl/serial_burst_router_if.sv
// rtl/serial_burst_router_if.sv - burst request and serial channel bundle for serial_burst_router
//
// Purpose: carries the burst request (start/len/ch_sel/abort), the incoming
// serial bit, and the per-channel serial outputs with status.
// Ports (signals):
//   start, len, ch_sel, abort, serial_in : requester -> router
//   serial_out, valid                    : router -> channels (CHANNELS wide)
//   busy, last, done, remaining, err     : router status
// Modports: master = requester side, slave = router side.
interface serial_burst_router_if #(
  parameter int CNT_W    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
);
  logic                start;
  logic [CNT_W-1:0]    len;
  logic [SEL_W-1:0]    ch_sel;
  logic                abort;
  logic                serial_in;
  logic [CHANNELS-1:0] serial_out;
  logic [CHANNELS-1:0] valid;
  logic                busy;
  logic                last;
  logic                done;
  logic [CNT_W-1:0]    remaining;
  logic [1:0]          err;

  modport master (
    output start, len, ch_sel, abort, serial_in,
    input  serial_out, valid, busy, last, done, remaining, err
  );

  modport slave (
    input  start, len, ch_sel, abort, serial_in,
    output serial_out, valid, busy, last, done, remaining, err
  );
endinterface

// File: rtl/serial_burst_router.sv
// rtl/serial_burst_router.sv - routes a serial bit stream to one channel for a counted burst
//
// Purpose: on an accepted start, routes serial_in to the latched channel for
// exactly len cycles, then pulses done for one cycle. abort terminates the
// burst early without done. err flags zero-length requests (bit0) and
// requests arriving while a burst is active (bit1).
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : serial_burst_router_if.slave (request, serial data, status)
module serial_burst_router #(
  parameter int CNT_W    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  serial_burst_router_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] remaining;
  logic [SEL_W-1:0] active;
  logic             done_q;
  logic [1:0]       err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      active    <= '0;
      done_q    <= 1'b0;
      err_q     <= 2'b00;
    end else begin
      done_q <= 1'b0;
      err_q  <= 2'b00;
      case (state)
        IDLE: begin
          // abort alongside start cancels the request outright, so no error either
          if (bus.start && !bus.abort) begin
            if (bus.len == '0) begin
              err_q[0] <= 1'b1;
            end else begin
              state     <= SEND;
              remaining <= bus.len;
              active    <= bus.ch_sel;
            end
          end
        end
        SEND: begin
          if (bus.start) err_q[1] <= 1'b1;
          // abort wins over the final-bit completion
          if (bus.abort) begin
            state     <= IDLE;
            remaining <= '0;
          end else if (remaining == CNT_W'(1)) begin
            state     <= DONE;
            remaining <= '0;
            done_q    <= 1'b1;
          end else begin
            remaining <= remaining - CNT_W'(1);
          end
        end
        DONE: begin
          if (bus.start) err_q[1] <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          remaining <= '0;
        end
      endcase
    end
  end

  // Channel decode by equality: an out-of-range active value matches no
  // channel, so the burst still times out but nothing is strobed.
  always_comb begin
    bus.valid      = '0;
    bus.serial_out = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (state == SEND && active == SEL_W'(i)) begin
        bus.valid[i]      = 1'b1;
        bus.serial_out[i] = bus.serial_in;
      end
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.last      = (state == SEND) && (remaining == CNT_W'(1));
  assign bus.done      = done_q;
  assign bus.remaining = remaining;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_serial_burst_router.sv
// tb/tb_serial_burst_router.sv - self-checking bench for serial_burst_router
module tb_serial_burst_router;
  localparam int CNT_W    = 8;
  localparam int CHANNELS = 4;
  localparam int SEL_W    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  serial_burst_router_if #(.CNT_W(CNT_W), .CHANNELS(CHANNELS), .SEL_W(SEL_W)) bus ();

  serial_burst_router #(.CNT_W(CNT_W), .CHANNELS(CHANNELS), .SEL_W(SEL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CHANNELS-1:0] onehot(input int c);
    logic [CHANNELS-1:0] v;
    v = '0;
    if (c < CHANNELS) v[c] = 1'b1;
    return v;
  endfunction

  task automatic chk_idle(input string tag, input logic [1:0] exp_err);
    chk({tag, ".busy"}, bus.busy, 0);
    chk({tag, ".valid"}, bus.valid, 0);
    chk({tag, ".serial_out"}, bus.serial_out, 0);
    chk({tag, ".done"}, bus.done, 0);
    chk({tag, ".last"}, bus.last, 0);
    chk({tag, ".remaining"}, bus.remaining, 0);
    chk({tag, ".err"}, bus.err, exp_err);
  endtask

  // Transaction-level model: an accepted burst of length l on channel ch is
  // SEND cycles k = 0..l-1 with remaining l-k, then one DONE cycle, then IDLE.
  // abort_at = SEND index where abort is held (-1: none); start_mid = SEND
  // index where a stray start is held (-1: none), whose err[1] shows one cycle later.
  task automatic run_burst(input int l, input int ch, input int abort_at, input int start_mid);
    int  last_k;
    bit  aborted;
    bit  si;
    aborted = 1'b0;
    @(posedge clk); #1;
    bus.start  = 1'b1;
    bus.len    = CNT_W'(l);
    bus.ch_sel = SEL_W'(ch);
    bus.abort  = 1'b0;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.len    = CNT_W'($urandom);
    bus.ch_sel = SEL_W'($urandom);
    last_k = l;
    for (int k = 0; k < l; k++) begin
      si = 1'($urandom_range(0, 1));
      bus.serial_in = si;
      bus.abort     = (k == abort_at);
      bus.start     = (k == start_mid);
      @(negedge clk);
      chk("send.valid", bus.valid, onehot(ch));
      chk("send.serial_out", bus.serial_out, si ? onehot(ch) : '0);
      chk("send.remaining", bus.remaining, l - k);
      chk("send.last", bus.last, (k == l - 1));
      chk("send.busy", bus.busy, 1);
      chk("send.done", bus.done, 0);
      chk("send.err", bus.err, (start_mid >= 0 && k == start_mid + 1) ? 2 : 0);
      bus.serial_in = ~si;
      #1;
      chk("send.serial_out_comb", bus.serial_out, (~si) ? onehot(ch) : '0);
      @(posedge clk); #1;
      if (k == abort_at) begin
        aborted = 1'b1;
        last_k  = k;
        break;
      end
    end
    bus.abort = 1'b0;
    bus.start = 1'b0;
    if (!aborted) begin
      @(negedge clk);
      chk("done.busy", bus.busy, 1);
      chk("done.done", bus.done, 1);
      chk("done.valid", bus.valid, 0);
      chk("done.serial_out", bus.serial_out, 0);
      chk("done.remaining", bus.remaining, 0);
      chk("done.last", bus.last, 0);
      chk("done.err", bus.err, (start_mid == l - 1) ? 2 : 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk_idle("after", (start_mid >= 0 && start_mid == last_k) ? 2'd2 : 2'd0);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.ch_sel    = '0;
    bus.abort     = 1'b0;
    bus.serial_in = 1'b1;

    // Reset state, before any clock edge
    #3;
    chk_idle("reset", 2'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // len=3 on channel 2
    run_burst(3, 2, -1, -1);

    // zero length: err[0] for one cycle, nothing else moves
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.len   = '0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk_idle("zlen", 2'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk_idle("zlen_next", 2'd0);

    // start together with abort in IDLE is ignored
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.len   = 8'd4;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    @(negedge clk);
    chk_idle("start_abort", 2'd0);

    // len=5 aborted on its 2nd SEND cycle
    run_burst(5, 1, 1, -1);

    // stray start during a len=4 burst
    run_burst(4, 3, -1, 1);

    // stray start on the final bit lands err[1] in DONE
    run_burst(2, 0, -1, 1);

    // longest legal burst
    run_burst(255, 2, -1, -1);

    // randomized bursts
    for (int r = 0; r < 8; r++) begin
      int l, ch, ab, sm;
      l  = $urandom_range(1, 20);
      ch = $urandom_range(0, CHANNELS - 1);
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, l - 1) : -1;
      sm = ($urandom_range(0, 2) == 0) ? $urandom_range(0, l - 1) : -1;
      if (ab >= 0 && sm > ab) sm = -1;
      run_burst(l, ch, ab, sm);
    end

    // asynchronous reset on the 2nd cycle of a len=6 burst
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.len       = 8'd6;
    bus.ch_sel    = 2'd1;
    bus.serial_in = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("rst.pre_remaining", bus.remaining, 6);
    @(posedge clk); #1;
    chk("rst.cycle2_remaining", bus.remaining, 5);
    #2;
    rst = 1'b1;
    #1;
    chk_idle("rst.async", 2'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_idle("rst.release", 2'd0);
    run_burst(1, 0, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
